pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Converts single-cycle event strobes (e.g. edge-detector outputs) back into visible level pulses for LEDs and slow peripherals.
- Each strobe produces one output pulse of a fixed width, followed by a guaranteed low gap.
- Strobes that arrive while a pulse is in progress are counted and replayed in order, so no event is lost until the queue saturates.
- Sits between the button-edge logic and the board outputs, on the single system clock.

Parameters:
- DIV, 4: clk cycles per timing tick; must be >= 1.
- HIGH_TICKS, 3: output high width in ticks; must be >= 1.
- LOW_TICKS, 2: minimum low gap between replayed pulses, in ticks; must be >= 1.
- PW, 3: width of the pending-event counter; saturates at 2^PW-1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- pulse_in  input  1  event strobe; every clk cycle it is high counts as one event.
- clr_ovf  input  1  synchronous clear of overflow.
- outlevel  output  1  stretched pulse output, registered.
- busy  output  1  high when state != IDLE or pending != 0.
- pending  output  PW  number of queued, not-yet-started events.
- overflow  output  1  sticky; set when an event is dropped.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, prescaler=0, tick counter=0, pending=0, outlevel=0, overflow=0, busy=0. Asserting reset mid-pulse forces outlevel low immediately and discards the queue.
- States: IDLE, HIGH, GAP. outlevel is registered and equals (state==HIGH).
- Prescaler:
  - Counts 0..DIV-1 only while in HIGH or GAP.
  - tick is asserted when prescaler==DIV-1.
  - The prescaler clears to 0 on every state entry, so HIGH lasts exactly HIGH_TICKS*DIV cycles and GAP lasts exactly LOW_TICKS*DIV cycles.
- Tick counter:
  - Loaded with HIGH_TICKS on entry to HIGH, and with LOW_TICKS on entry to GAP.
  - Decrements on tick. The state ends on the tick at which the counter equals 1.
- start = (IDLE and (pending!=0 or pulse_in)) or (GAP ending and (pending!=0 or pulse_in)).
- Transitions:
  - IDLE -> HIGH on start.
  - HIGH -> GAP at the end of its count.
  - GAP -> HIGH at the end of its count if start; otherwise GAP -> IDLE. A queued event is replayed directly after the gap, with no extra idle cycle.
- Latency: pulse_in sampled high at edge k while IDLE with pending=0 gives outlevel=1 after edge k, held for HIGH_TICKS*DIV cycles.
- Pending-counter update, with inc=pulse_in and dec=start:
  - inc and dec both high: pending unchanged. An event that starts immediately is never queued.
  - inc only: pending+1. If pending == 2^PW-1, pending holds and overflow is set (event dropped).
  - dec only: pending-1. dec is only possible when pending != 0 or inc is high, so pending never underflows.
- overflow stays set until clr_ovf=1. If clr_ovf and a new drop occur in the same cycle, set wins.
- pulse_in held high for N cycles counts as N events. Level-to-pulse conversion is the upstream block's job.
- Counter widths: prescaler is clog2(DIV) bits, minimum 1. Tick counter is sized to hold max(HIGH_TICKS, LOW_TICKS).

Test Plan (DIV=4, HIGH_TICKS=3, LOW_TICKS=2, PW=3):
- Single 1-cycle pulse_in from IDLE -> outlevel high for exactly 12 cycles starting at the next edge, then low. busy high for 20 cycles. pending stays 0.
- Three pulses on consecutive cycles -> pending goes 0,1,2. Output is three 12-cycle high windows separated by exactly 8 low cycles. pending reaches 0 at the start of the third window. busy drops 8 cycles after the third window ends.
- Nine pulses on consecutive cycles -> pending saturates at 7 and overflow=1 on the 9th. Exactly 8 output pulses. overflow persists after the queue drains; clr_ovf=1 clears it.
- pulse_in on the last GAP cycle with pending=0 -> GAP->HIGH on the next edge with no idle cycle. pending stays 0 and only 8 low cycles appear between the pulses.
- reset driven low for one cycle, 5 cycles into a HIGH window with pending=2 -> outlevel, busy, pending and overflow are all 0 immediately. After release, the block stays IDLE until the next pulse_in.
- clr_ovf and a dropped event in the same cycle with pending=7 -> overflow remains 1.

Source files
------------

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches single-cycle event strobes into fixed-width level pulses with queued replay
module pulse_stretcher #(
  parameter int DIV        = 4,
  parameter int HIGH_TICKS = 3,
  parameter int LOW_TICKS  = 2,
  parameter int PW         = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pulse_in,
  input  logic          clr_ovf,
  output logic          outlevel,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  // Prescaler needs at least one bit even when every clk cycle is a tick.
  localparam int PSW     = (DIV > 1) ? $clog2(DIV) : 1;
  // Tick counter must hold the larger of the two phase lengths.
  localparam int MAX_TK  = (HIGH_TICKS > LOW_TICKS) ? HIGH_TICKS : LOW_TICKS;
  localparam int TCW     = $clog2(MAX_TK + 1);

  localparam logic [PSW-1:0] PRE_LAST  = PSW'(DIV - 1);
  localparam logic [TCW-1:0] HIGH_LOAD = TCW'(HIGH_TICKS);
  localparam logic [TCW-1:0] LOW_LOAD  = TCW'(LOW_TICKS);
  localparam logic [PW-1:0]  PEND_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t         state;
  logic [PSW-1:0] prescaler;
  logic [TCW-1:0] tick_cnt;

  logic tick;
  logic last_tick;
  logic high_end;
  logic gap_end;
  logic have_event;
  logic start;
  logic pend_full;
  logic drop;

  // Timing decode and start/drop qualification from the current registered state.
  always_comb begin
    tick       = 1'b0;
    last_tick  = 1'b0;
    high_end   = 1'b0;
    gap_end    = 1'b0;
    have_event = 1'b0;
    start      = 1'b0;
    pend_full  = 1'b0;
    drop       = 1'b0;

    tick       = (state != IDLE) && (prescaler == PRE_LAST);
    last_tick  = tick && (tick_cnt == TCW'(1));
    high_end   = (state == HIGH) && last_tick;
    gap_end    = (state == GAP) && last_tick;
    // A strobe arriving this cycle can start a pulse directly, bypassing the queue.
    have_event = (pending != '0) || pulse_in;
    start      = ((state == IDLE) || gap_end) && have_event;
    pend_full  = (pending == PEND_MAX);
    // An incoming strobe that cannot start and finds the queue full is lost.
    drop       = pulse_in && !start && pend_full;
  end

  // Pulse sequencer: IDLE -> HIGH -> GAP -> (HIGH | IDLE), with registered output level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prescaler <= '0;
      tick_cnt  <= '0;
      outlevel  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= HIGH;
            outlevel  <= 1'b1;
            prescaler <= '0;
            tick_cnt  <= HIGH_LOAD;
          end
        end

        HIGH: begin
          if (high_end) begin
            state     <= GAP;
            outlevel  <= 1'b0;
            prescaler <= '0;
            tick_cnt  <= LOW_LOAD;
          end else begin
            prescaler <= tick ? '0 : prescaler + PSW'(1);
            if (tick) begin
              tick_cnt <= tick_cnt - TCW'(1);
            end
          end
        end

        GAP: begin
          if (gap_end) begin
            prescaler <= '0;
            if (start) begin
              // Back-to-back replay: no idle cycle between gap and next pulse.
              state    <= HIGH;
              outlevel <= 1'b1;
              tick_cnt <= HIGH_LOAD;
            end else begin
              state    <= IDLE;
              outlevel <= 1'b0;
              tick_cnt <= '0;
            end
          end else begin
            prescaler <= tick ? '0 : prescaler + PSW'(1);
            if (tick) begin
              tick_cnt <= tick_cnt - TCW'(1);
            end
          end
        end

        default: begin
          state     <= IDLE;
          outlevel  <= 1'b0;
          prescaler <= '0;
          tick_cnt  <= '0;
        end
      endcase
    end
  end

  // Pending-event queue depth: strobes add, pulse starts remove, saturates at full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      case ({pulse_in, start})
        2'b10: begin
          if (!pend_full) begin
            pending <= pending + PW'(1);
          end
        end
        2'b01: pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign busy = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - scoreboard bench for pulse_stretcher
module tb_pulse_stretcher;

  localparam int PW = 3;

  logic          clk;
  logic          reset;
  logic          pulse_in;
  logic          clr_ovf;
  logic          outlevel;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int width;
    int gap;
  } pulse_t;

  pulse_t exp_q[$];

  pulse_stretcher #(
    .DIV(4),
    .HIGH_TICKS(3),
    .LOW_TICKS(2),
    .PW(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pulse_in(pulse_in),
    .clr_ovf(clr_ovf),
    .outlevel(outlevel),
    .busy(busy),
    .pending(pending),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_pulse(input int gap);
    pulse_t p;
    p.width = 12;
    p.gap   = gap;
    exp_q.push_back(p);
  endtask

  // Counts consecutive busy cycles from the current negedge until busy drops.
  task automatic count_busy(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      n++;
      @(negedge clk);
    end
    if (busy) check("busy_timeout", 1, 0);
  endtask

  // Output monitor: measures every high window and the low run before it.
  int  hi_run   = 0;
  int  lo_run   = 0;
  int  last_gap = -1;
  bit  have_prev = 0;

  always @(negedge clk) begin
    if (!reset) begin
      hi_run    = 0;
      lo_run    = 0;
      last_gap  = -1;
      have_prev = 0;
    end else if (outlevel) begin
      if (hi_run == 0) last_gap = have_prev ? lo_run : -1;
      hi_run++;
    end else begin
      if (hi_run != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          pulse_t e;
          e = exp_q.pop_front();
          check("pulse_width", hi_run, e.width);
          if (e.gap >= 0) check("pulse_gap", last_gap, e.gap);
        end
        hi_run    = 0;
        lo_run    = 0;
        have_prev = 1;
      end
      lo_run++;
    end
  end

  int n;
  int highs;

  initial begin
    reset    = 1'b0;
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_outlevel", outlevel, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single strobe from idle: 12 high + 8 gap = 20 busy cycles.
    pulse_in = 1'b1; push_pulse(-1);
    @(negedge clk);
    check("t1_out_latency", outlevel, 1);
    check("t1_pending", pending, 0);
    pulse_in = 1'b0;
    count_busy(100, n);
    check("t1_busy_len", n, 20);
    repeat (3) @(negedge clk);

    // Three consecutive strobes: pending 0,1,2 then three windows.
    for (int i = 0; i < 3; i++) begin
      pulse_in = 1'b1;
      push_pulse(i == 0 ? -1 : 8);
      @(negedge clk);
      check("t2_pending", pending, i);
    end
    pulse_in = 1'b0;
    // busy spans 3*(12+8)=60 cycles, 2 of which already passed
    count_busy(200, n);
    check("t2_busy_len", n, 58);
    repeat (3) @(negedge clk);

    // Nine strobes: 8 accepted, 9th dropped, overflow sticky until cleared.
    for (int i = 0; i < 9; i++) begin
      pulse_in = 1'b1;
      if (i < 8) push_pulse(i == 0 ? -1 : 8);
      @(negedge clk);
      if (i == 7) check("t3_pending_full", pending, 7);
      if (i == 7) check("t3_ovf_before", overflow, 0);
    end
    pulse_in = 1'b0;
    check("t3_pending_sat", pending, 7);
    check("t3_ovf_set", overflow, 1);
    // 8 pulses * 20 cycles = 160, 8 already passed
    count_busy(400, n);
    check("t3_busy_len", n, 152);
    check("t3_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t3_ovf_clr", overflow, 0);
    repeat (3) @(negedge clk);

    // Clear and drop in the same cycle: set wins.
    for (int i = 0; i < 9; i++) begin
      pulse_in = 1'b1;
      if (i < 8) push_pulse(i == 0 ? -1 : 8);
      if (i == 8) clr_ovf = 1'b1;
      @(negedge clk);
    end
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    check("t4_pending", pending, 7);
    check("t4_ovf_set_wins", overflow, 1);
    count_busy(400, n);
    check("t4_busy_len", n, 152);
    repeat (3) @(negedge clk);

    // Strobe on the last gap cycle: replay straight into HIGH.
    pulse_in = 1'b1; push_pulse(-1);
    @(negedge clk);
    pulse_in = 1'b0;
    repeat (19) @(negedge clk);
    check("t5_in_gap", outlevel, 0);
    pulse_in = 1'b1; push_pulse(8);
    @(negedge clk);
    pulse_in = 1'b0;
    check("t5_back_to_back", outlevel, 1);
    check("t5_pending", pending, 0);
    count_busy(100, n);
    check("t5_busy_len", n, 20);
    repeat (3) @(negedge clk);

    // Reset mid-pulse with pending=2 and overflow still set.
    for (int i = 0; i < 3; i++) begin
      pulse_in = 1'b1;
      @(negedge clk);
    end
    pulse_in = 1'b0;
    check("t6_pending_pre", pending, 2);
    check("t6_ovf_pre", overflow, 1);
    @(negedge clk);
    @(negedge clk);
    check("t6_high_pre", outlevel, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_outlevel", outlevel, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pending", pending, 0);
    check("t6_rst_overflow", overflow, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    highs = 0;
    repeat (12) begin
      @(negedge clk);
      if (outlevel || busy) highs++;
    end
    check("t6_stays_idle", highs, 0);
    pulse_in = 1'b1; push_pulse(-1);
    @(negedge clk);
    pulse_in = 1'b0;
    check("t6_restart", outlevel, 1);
    count_busy(100, n);
    check("t6_busy_len", n, 20);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
